// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and round-transform helpers for the cipher datapath.
// State bytes are column-major; byte 0 occupies bits [127:120].
package aes_pkg;

  localparam int NR        = 10;
  localparam int KEY_IDX_W = 4;
  localparam logic [KEY_IDX_W-1:0] NR_IDX = KEY_IDX_W'(NR);

  typedef logic [0:15][7:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } aes_fsm_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Output byte (r, c) takes input byte (r, (c + r) mod 4).
  function automatic aes_state_t shift_rows(input aes_state_t s);
    aes_state_t r;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[4*c+row] = s[4*((c+row)%4)+row];
      end
    end
    return r;
  endfunction

  function automatic aes_state_t mix_columns(input aes_state_t s);
    aes_state_t r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[4*c];
      a1 = s[4*c+1];
      a2 = s[4*c+2];
      a3 = s[4*c+3];
      r[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      r[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      r[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      r[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return r;
  endfunction

  function automatic aes_state_t add_round_key(input aes_state_t s, input aes_state_t k);
    return s ^ k;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single forward AES S-box lookup; shared by the cipher rounds and the key expansion.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryption core: one full round per clock, round keys fetched by index.
// Define AES_ENC_ROUND_TAP_EN to expose the per-round debug tap (dbg_state/dbg_round/dbg_strobe).
module aes_enc_iter
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [127:0]         data_in,
  output logic [KEY_IDX_W-1:0] key_idx,
  input  logic [127:0]         round_key,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [127:0]         data_out
`ifdef AES_ENC_ROUND_TAP_EN
  ,
  output logic [127:0]         dbg_state,
  output logic [KEY_IDX_W-1:0] dbg_round,
  output logic                 dbg_strobe
`endif
);

  aes_fsm_e             state_q, state_d;
  logic [KEY_IDX_W-1:0] round_q, round_d;
  aes_state_t           data_q, data_d;
  aes_state_t           sub_bytes, shifted, mixed, round_out;
  logic                 accept;

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (data_q[i]),
      .out_byte (sub_bytes[i])
    );
  end

  // The final round bypasses MixColumns.
  always_comb begin
    shifted   = shift_rows(sub_bytes);
    mixed     = (round_q == NR_IDX) ? shifted : mix_columns(shifted);
    round_out = add_round_key(mixed, round_key);
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = add_round_key(data_in, round_key);
          round_d = KEY_IDX_W'(1);
          state_d = ROUND;
        end
      end
      ROUND: begin
        data_d  = round_out;
        round_d = round_q + KEY_IDX_W'(1);
        if (round_q == NR_IDX) state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          round_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      round_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      data_q  <= data_d;
    end
  end

  // in_ready is held low for as long as reset is asserted.
  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign data_out  = (state_q == DONE) ? data_q : '0;
  assign key_idx   = (state_q == ROUND) ? round_q : '0;

`ifdef AES_ENC_ROUND_TAP_EN
  logic strobe_q, strobe_d;

  always_comb begin
    strobe_d = (state_q == ROUND) || ((state_q == IDLE) && accept);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= strobe_d;
    end
  end

  assign dbg_state  = data_q;
  assign dbg_round  = round_q;
  assign dbg_strobe = strobe_q;
`endif

endmodule

// File: tb/tb_aes_enc_iter.sv
// Self-checking bench for aes_enc_iter: FIPS-197 vectors, backpressure, back-to-back and reset.
// Round keys come from an independent key-expansion model with its own computed S-box.
module tb_aes_enc_iter;

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic [3:0]   key_idx;
  logic [127:0] round_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
`ifdef AES_ENC_ROUND_TAP_EN
  logic [127:0] dbg_state;
  logic [3:0]   dbg_round;
  logic         dbg_strobe;
  logic         tap_armed = 1'b0;
`endif

  logic [127:0] rk [0:10];
  logic [127:0] exp_cur;
  logic [127:0] exp_q [$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;

  aes_enc_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .key_idx   (key_idx),
    .round_key (round_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
`ifdef AES_ENC_ROUND_TAP_EN
    ,
    .dbg_state  (dbg_state),
    .dbg_round  (dbg_round),
    .dbg_strobe (dbg_strobe)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behaves like the external key store: combinational lookup by index.
  always_comb begin
    round_key = '0;
    if (key_idx <= 4'd10) round_key = rk[key_idx];
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, observed=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] model_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse then the affine map.
  function automatic logic [7:0] model_sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int i = 1; i < 256; i++) begin
      if (model_mul(x, 8'(i)) == 8'h01) inv = 8'(i);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {model_sbox(t[31:24]), model_sbox(t[23:16]), model_sbox(t[15:8]), model_sbox(t[7:0])}
            ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] key,
                               input logic [127:0] ct);
    data_in = pt;
    expand_key(key);
    exp_cur = ct;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_scoreboard();
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard: observed=empty expected=pending entry");
    end
    if (exp_q.size() > 0) checkOutput("ciphertext", data_out, exp_q.pop_front());
  endtask

  // Accept one block and wait for out_valid, checking latency and optionally key_idx.
  task automatic run_block(input bit chk_key_idx);
    int lat;
    int guard;
    int strobes;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("accept_ready", in_ready, 1);
    if (chk_key_idx) checkOutput("key_idx_idle", key_idx, 0);
    in_valid = 1'b1;
    exp_q.push_back(exp_cur);
    @(negedge clk);
    in_valid = 1'b0;
    data_in  = '0;
    lat      = 0;
    strobes  = 0;
    while (!out_valid && lat < 30) begin
      if (chk_key_idx) checkOutput($sformatf("key_idx_r%0d", lat + 1), key_idx, lat + 1);
`ifdef AES_ENC_ROUND_TAP_EN
      if (dbg_strobe) strobes++;
      if (lat == 1 && tap_armed) begin
        checkOutput("dbg_state_e1", dbg_state, 128'ha49c7ff2689f352b6b5bea43026a5049);
        checkOutput("dbg_round_e1", dbg_round, 2);
      end
`endif
      @(negedge clk);
      lat++;
    end
`ifdef AES_ENC_ROUND_TAP_EN
    if (dbg_strobe) strobes++;
    checkOutput("dbg_strobe_count", strobes, 11);
`endif
    checkOutput("latency", lat, 10);
  endtask

  task automatic drain_one();
    checkOutput("out_valid_done", out_valid, 1);
    checkOutput("in_ready_done", in_ready, 0);
    check_scoreboard();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("out_valid_drop", out_valid, 0);
    checkOutput("in_ready_rise", in_ready, 1);
  endtask

  initial begin
    int guard;
    int accepts;
    int outs;
    int acc_edge [2];
    int out_edge [2];

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    exp_cur   = '0;
    for (int k = 0; k < 11; k++) rk[k] = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_key_idx", key_idx, 0);
    checkOutput("rst_data_out", data_out, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_in_ready", in_ready, 1);

    // FIPS-197 Appendix B.
    $display("[TB] App. B vector");
    applyStimulus(PT_B, KEY_B, CT_B);
`ifdef AES_ENC_ROUND_TAP_EN
    tap_armed = 1'b1;
`endif
    run_block(1'b0);
`ifdef AES_ENC_ROUND_TAP_EN
    tap_armed = 1'b0;
`endif
    drain_one();

    // FIPS-197 Appendix C.1 with key_idx sequence.
    $display("[TB] App. C.1 vector");
    applyStimulus(PT_C, KEY_C, CT_C);
    run_block(1'b1);
    drain_one();

    // Backpressure: ciphertext held for 20 cycles while in_valid pulses are ignored.
    $display("[TB] backpressure");
    applyStimulus(PT_B, KEY_B, CT_B);
    run_block(1'b0);
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      data_in  = {4{32'hdeadbeef}} ^ 128'(i);
      @(negedge clk);
      checkOutput("bp_out_valid", out_valid, 1);
      checkOutput("bp_data_out", data_out, CT_B);
      checkOutput("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    drain_one();

    // Back-to-back: in_valid and out_ready held high.
    $display("[TB] back-to-back");
    applyStimulus(PT_C, KEY_C, CT_C);
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    accepts   = 0;
    outs      = 0;
    guard     = 0;
    acc_edge  = '{0, 0};
    out_edge  = '{0, 0};
    while (outs < 2 && guard < 80) begin
      if (accepts == 2) in_valid = 1'b0;
      if (in_valid && in_ready) begin
        exp_q.push_back(exp_cur);
        acc_edge[accepts] = cyc + 1;
        accepts++;
      end
      if (out_valid) begin
        check_scoreboard();
        out_edge[outs] = cyc;
        outs++;
      end
      @(negedge clk);
      guard++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput("b2b_outputs", outs, 2);
    checkOutput("b2b_accepts", accepts, 2);
    checkOutput("b2b_latency1", out_edge[0] - acc_edge[0], 10);
    checkOutput("b2b_gap", acc_edge[1] - out_edge[0], 2);
    checkOutput("b2b_latency2", out_edge[1] - acc_edge[1], 10);
    checkOutput("b2b_sb_empty", exp_q.size(), 0);

    // Reset asserted asynchronously in round 5; the block in flight is dropped.
    $display("[TB] reset mid-flight");
    applyStimulus(PT_B, KEY_B, CT_B);
    @(negedge clk);
    in_valid = 1'b1;
    exp_q.push_back(exp_cur);
    @(negedge clk);
    in_valid = 1'b0;
    guard    = 0;
    while (key_idx != 4'd5 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("mid_round5", key_idx, 5);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checkOutput("mid_out_valid", out_valid, 0);
    checkOutput("mid_in_ready", in_ready, 0);
    checkOutput("mid_key_idx", key_idx, 0);
    checkOutput("mid_data_out", data_out, 0);
    repeat (2) @(negedge clk);
    checkOutput("mid_hold_out_valid", out_valid, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("mid_rel_in_ready", in_ready, 1);
    checkOutput("mid_rel_key_idx", key_idx, 0);
    applyStimulus(PT_B, KEY_B, CT_B);
    run_block(1'b0);
    drain_one();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
